note_key_encoder: RTL and testbench
===================================

Name: note_key_encoder

Overview:
- Front-end stage directly upstream of the song-tracking state machines; its output drives their 4-bit `note` input.
- Takes the eight raw piano key inputs (switches/buttons, active-high, asynchronous to CLK).
- Synchronises and debounces each key, then encodes the single pressed key into the shared 4-bit note code.
- Also emits a one-cycle strobe on every new note onset.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed before a key change is accepted (10 ms at 100 MHz); legal range 1..2^CNT_W.
- CNT_W, 20, width of each per-key debounce counter.

Ports:
- CLK  input  1  system clock.
- RESET_N  input  1  asynchronous, active-low reset.
- keys  input  8  raw key levels, 1 = pressed. Bit order: bit0 = C4, bit1 = D, bit2 = E, bit3 = F, bit4 = G, bit5 = A, bit6 = B, bit7 = C5.
- note  output  4  registered note code. Codes are the shared parameter-include values: none = 0, C4 = 1, D = 2, E = 3, F = 4, G = 5, A = 6, B = 7, C5 = 8.
- note_strobe  output  1  one-cycle pulse on the cycle `note` takes a new non-none value.
- deb_keys  output  8  debounced key levels, for LEDs and debug.

Behaviour:
- Clock and reset:
  - Single clock domain, posedge CLK.
  - Clock and reset are fixed as one clock, reset asynchronous and active-low.
  - RESET_N low immediately clears all state. This applies at any time, including mid-debounce or mid-note.
- Reset values:
  - Synchroniser flops = 0.
  - deb_keys = 8'h00.
  - All counters = 0.
  - note = none (0).
  - note_strobe = 0.
- Synchroniser:
  - Each bit of `keys` passes through two flops.
  - The second flop output is the sampled level s[i].
- Debounce, per key i, evaluated each edge:
  - If s[i] == deb_keys[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: deb_keys[i] <= s[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - A bounce back to the old level before acceptance restarts the count.
  - Press and release are debounced identically.
- Encoder, combinational from deb_keys, registered into `note`:
  - Exactly one bit set: `note` = that key's code.
  - Zero bits set: `note` = none.
  - Two or more bits set (chord): `note` = none.
- Strobe:
  - note_strobe = 1 for exactly one cycle, on the edge where the `note` register loads a value that is non-none and different from its previous value.
  - No strobe for a change to none.
  - No strobe while a note is held.
  - Chord release leaving one key held counts as a new note and strobes. Example: sequence E → none (chord) → E gives a second strobe.
- Latency:
  - Reference point: raw key level stable from sampling edge 0.
  - deb_keys updates at edge DEBOUNCE_CYCLES+1.
  - `note` and note_strobe update at edge DEBOUNCE_CYCLES+2.
- Boundary cases:
  - DEBOUNCE_CYCLES = 1 accepts a change after one stable sampled cycle.
  - The counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.
  - Simultaneous acceptance on several keys in the same edge is evaluated together. The encoder sees the final vector, with no intermediate single-key code.
- Downstream contract: every accepted note is followed by `none` before the next note, unless the key changes directly (slide). A direct key change yields a code change with a strobe but no `none` in between.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset:
  - Hold RESET_N low, keys=8'hFF.
  - Then release RESET_N with keys=0.
  - Required: note=0, deb_keys=0, note_strobe=0 throughout, and no strobe after release.
- Clean press/release:
  - Set keys=8'h04 (E) at edge 0 and hold 20 cycles, then keys=0.
  - Required: note=3 and a single note_strobe pulse at edge 6.
  - Required: note=0 six edges after the release, with no strobe.
- Bounce rejection:
  - Toggle keys[3] 1,0,1,0 every 2 cycles, then hold at 1.
  - Required: note stays 0 until 6 edges after the final stable 1, then note=4 (F) with one strobe.
- Chord:
  - Press G (8'h10) and hold it.
  - Add A (8'h30); later release G (8'h20).
  - Required: note=5 with a strobe, then 0 with no strobe, then 6 with a strobe.
  - Each transition appears 6 edges after its stimulus.
- Slide and melody:
  - Drive E,none,E,none,F,none,G with each level held 10 cycles.
  - Required: note sequence 3,0,3,0,4,0,5 with exactly four strobes.
  - Chain to the song checker and confirm it advances to its 7th state.
- Reset mid-debounce:
  - Press C5 (8'h80) and assert RESET_N low at cycle 3.
  - Release reset with the key still held.
  - Required: note=0 during reset; note=8 exactly 6 edges after the first post-reset edge.

Source files
------------

// File: rtl/note_key_encoder.sv
// Synchronises and debounces eight piano keys, then encodes a single pressed key into a 4-bit note code.
// Latency: DEBOUNCE_CYCLES+1 edges to deb_keys, DEBOUNCE_CYCLES+2 edges to note/note_strobe.
// Backpressure: none; free-running stage with no handshake, and the output is always valid.
module note_key_encoder #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] keys,
    output logic [3:0] note,
    output logic       note_strobe,
    output logic [7:0] deb_keys
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Note codes shared with the song-tracking state machines.
    localparam logic [3:0] NOTE_NONE = 4'd0;
    localparam logic [3:0] NOTE_C4   = 4'd1;
    localparam logic [3:0] NOTE_D    = 4'd2;
    localparam logic [3:0] NOTE_E    = 4'd3;
    localparam logic [3:0] NOTE_F    = 4'd4;
    localparam logic [3:0] NOTE_G    = 4'd5;
    localparam logic [3:0] NOTE_A    = 4'd6;
    localparam logic [3:0] NOTE_B    = 4'd7;
    localparam logic [3:0] NOTE_C5   = 4'd8;

    logic [7:0]       sync1;
    logic [7:0]       sync2;
    logic [CNT_W-1:0] cnt [8];
    logic [3:0]       next_note;
    logic             next_strobe;

    // Two-flop synchroniser; sync2 is the sampled key level.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1 <= 8'h00;
            sync2 <= 8'h00;
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
        end
    end

    // Per-key debounce: a level change is accepted only after it has been seen
    // for DEBOUNCE_CYCLES consecutive edges; any bounce back restarts the count.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            deb_keys <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (sync2[i] == deb_keys[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST_CNT) begin
                    deb_keys[i] <= sync2[i];
                    cnt[i]      <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // One-hot key vector to note code; silence and chords both map to none.
    // The strobe fires only when a new, non-none code is about to load.
    always_comb begin
        next_note = NOTE_NONE;
        case (deb_keys)
            8'h01:   next_note = NOTE_C4;
            8'h02:   next_note = NOTE_D;
            8'h04:   next_note = NOTE_E;
            8'h08:   next_note = NOTE_F;
            8'h10:   next_note = NOTE_G;
            8'h20:   next_note = NOTE_A;
            8'h40:   next_note = NOTE_B;
            8'h80:   next_note = NOTE_C5;
            default: next_note = NOTE_NONE;
        endcase
        next_strobe = (next_note != NOTE_NONE) && (next_note != note);
    end

    // Registered note code and onset strobe.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            note        <= NOTE_NONE;
            note_strobe <= 1'b0;
        end else begin
            note        <= next_note;
            note_strobe <= next_strobe;
        end
    end

endmodule

// File: tb/tb_note_key_encoder.sv
// Directed bench for note_key_encoder with a short debounce window.
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit after an edge.
// Strobes and note changes are also tallied on falling edges for sequence checks.
module tb_note_key_encoder;

    logic       CLK;
    logic       RESET_N;
    logic [7:0] keys;
    logic [3:0] note;
    logic       note_strobe;
    logic [7:0] deb_keys;

    int n_cmp;
    int n_bad;
    int strobe_total;
    int strobe_base;

    // Melody matcher: advances on each note change that matches the expected tune.
    logic [3:0] melody [7];
    bit         melody_en;
    int         melody_idx;
    logic [3:0] prev_note;

    note_key_encoder #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (20)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .keys       (keys),
        .note       (note),
        .note_strobe(note_strobe),
        .deb_keys   (deb_keys)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count strobes and track the melody on falling edges.
    always @(negedge CLK) begin
        if (note_strobe === 1'b1) strobe_total++;
        if (melody_en && note !== prev_note) begin
            if (melody_idx < 7 && note === melody[melody_idx]) melody_idx++;
        end
        prev_note = note;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        strobe_total = 0;
        melody_en    = 1'b0;
        melody_idx   = 0;
        prev_note    = 4'd0;
        melody[0] = 4'd3; melody[1] = 4'd0; melody[2] = 4'd3; melody[3] = 4'd0;
        melody[4] = 4'd4; melody[5] = 4'd0; melody[6] = 4'd5;

        // Reset held with every key pressed.
        RESET_N = 1'b0;
        keys    = 8'hFF;
        tick(10);
        chk("rst_note", {4'd0, note}, 8'd0);
        chk("rst_deb", deb_keys, 8'h00);
        chk("rst_strobe", {7'd0, note_strobe}, 8'd0);

        // Release reset with keys idle: nothing may happen.
        RESET_N = 1'b1;
        keys    = 8'h00;
        strobe_base = strobe_total;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("post_rst_note", {4'd0, note}, 8'd0);
            chk("post_rst_strobe", {7'd0, note_strobe}, 8'd0);
        end
        chk("post_rst_strobes", 8'(strobe_total - strobe_base), 8'd0);

        // Clean press of E.
        keys = 8'h04;
        strobe_base = strobe_total;
        tick(6);
        chk("e_deb_edge5", deb_keys, 8'h04);
        chk("e_note_edge5", {4'd0, note}, 8'd0);
        tick(1);
        chk("e_note_edge6", {4'd0, note}, 8'd3);
        chk("e_strobe_edge6", {7'd0, note_strobe}, 8'd1);
        tick(1);
        chk("e_strobe_edge7", {7'd0, note_strobe}, 8'd0);
        tick(12);
        chk("e_held_note", {4'd0, note}, 8'd3);
        chk("e_press_strobes", 8'(strobe_total - strobe_base), 8'd1);

        // Release E.
        keys = 8'h00;
        strobe_base = strobe_total;
        tick(6);
        chk("e_rel_edge5", {4'd0, note}, 8'd3);
        tick(1);
        chk("e_rel_edge6", {4'd0, note}, 8'd0);
        chk("e_rel_strobe", {7'd0, note_strobe}, 8'd0);
        tick(4);
        chk("e_rel_strobes", 8'(strobe_total - strobe_base), 8'd0);

        // Bounce on F, then a stable press.
        strobe_base = strobe_total;
        for (int b = 0; b < 4; b++) begin
            keys = (b % 2 == 0) ? 8'h08 : 8'h00;
            tick(2);
            chk("bounce_note", {4'd0, note}, 8'd0);
            chk("bounce_deb", deb_keys, 8'h00);
        end
        keys = 8'h08;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("bounce_settle_note", {4'd0, note}, 8'd0);
        end
        tick(1);
        chk("f_note", {4'd0, note}, 8'd4);
        chk("f_strobe", {7'd0, note_strobe}, 8'd1);
        tick(3);
        chk("f_strobes", 8'(strobe_total - strobe_base), 8'd1);
        keys = 8'h00;
        tick(10);
        chk("f_rel_note", {4'd0, note}, 8'd0);

        // Chord: G, then G+A, then A alone.
        keys = 8'h10;
        tick(7);
        chk("g_note", {4'd0, note}, 8'd5);
        chk("g_strobe", {7'd0, note_strobe}, 8'd1);
        tick(10);
        keys = 8'h30;
        strobe_base = strobe_total;
        tick(6);
        chk("chord_edge5", {4'd0, note}, 8'd5);
        tick(1);
        chk("chord_note", {4'd0, note}, 8'd0);
        chk("chord_strobe", {7'd0, note_strobe}, 8'd0);
        tick(10);
        chk("chord_strobes", 8'(strobe_total - strobe_base), 8'd0);
        keys = 8'h20;
        tick(6);
        chk("a_edge5", {4'd0, note}, 8'd0);
        tick(1);
        chk("a_note", {4'd0, note}, 8'd6);
        chk("a_strobe", {7'd0, note_strobe}, 8'd1);
        keys = 8'h00;
        tick(10);
        chk("a_rel_note", {4'd0, note}, 8'd0);

        // Melody E,none,E,none,F,none,G, each level held 10 cycles.
        strobe_base = strobe_total;
        melody_idx  = 0;
        melody_en   = 1'b1;
        begin
            logic [7:0] lv [7];
            lv[0] = 8'h04; lv[1] = 8'h00; lv[2] = 8'h04; lv[3] = 8'h00;
            lv[4] = 8'h08; lv[5] = 8'h00; lv[6] = 8'h10;
            for (int s = 0; s < 7; s++) begin
                keys = lv[s];
                tick(7);
                chk("melody_note", {4'd0, note}, {4'd0, melody[s]});
                chk("melody_strobe", {7'd0, note_strobe}, (melody[s] != 4'd0) ? 8'd1 : 8'd0);
                tick(3);
            end
        end
        melody_en = 1'b0;
        chk("melody_strobes", 8'(strobe_total - strobe_base), 8'd4);
        chk("melody_state", 8'(melody_idx), 8'd7);
        keys = 8'h00;
        tick(10);

        // Reset in the middle of a C5 debounce.
        keys = 8'h80;
        tick(3);
        RESET_N = 1'b0;
        #1;
        chk("mid_rst_note", {4'd0, note}, 8'd0);
        tick(3);
        chk("mid_rst_deb", deb_keys, 8'h00);
        chk("mid_rst_note2", {4'd0, note}, 8'd0);
        RESET_N = 1'b1;
        tick(6);
        chk("c5_edge5", {4'd0, note}, 8'd0);
        tick(1);
        chk("c5_note", {4'd0, note}, 8'd8);
        chk("c5_strobe", {7'd0, note_strobe}, 8'd1);

        // Asynchronous reset clears a held note without waiting for an edge.
        tick(2);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("async_rst_note", {4'd0, note}, 8'd0);
        chk("async_rst_deb", deb_keys, 8'h00);
        RESET_N = 1'b1;
        keys    = 8'h00;
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
